shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 141 ++++++++++++++
 tb/tb_shift_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-free shifter that produces the ARM-style second ALU operand
// (Val2) and shifter carry, moving at most BITS_PER_CYCLE bit positions per cycle.
module shift_sequencer #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic        memInst,
  input  logic        imm,
  input  logic        carryIn,
  input  logic [31:0] Val_Rm,
  input  logic [11:0] Shift_operand,
  output logic        busy,
  output logic        done,
  output logic [31:0] Val2,
  output logic        shift_carry
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {K_LSL, K_LSR, K_ASR, K_ROR} kind_t;

  localparam logic [4:0] STEP_MAX = 5'(BITS_PER_CYCLE);

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [31:0] work_q, work_d;
  logic        carry_q, carry_d;
  logic [4:0]  rem_q, rem_d;

  logic        accept;
  logic [31:0] acc_work;
  kind_t       acc_kind;
  logic [4:0]  acc_n;

  logic [4:0]  step;
  logic [5:0]  lidx;
  logic [4:0]  ridx;
  logic [31:0] shifted;
  logic        shifted_out;

  // Operand decode for the three instruction forms; memInst wins over imm.
  always_comb begin
    acc_work = Val_Rm;
    acc_kind = kind_t'(Shift_operand[6:5]);
    acc_n    = Shift_operand[11:7];
    if (memInst) begin
      acc_work = {{20{Shift_operand[11]}}, Shift_operand};
      acc_kind = K_LSL;
      acc_n    = 5'd0;
    end else if (imm) begin
      acc_work = {24'd0, Shift_operand[7:0]};
      acc_kind = K_ROR;
      acc_n    = {Shift_operand[11:8], 1'b0};
    end
  end

  // One step of k positions; lidx/ridx locate the last bit pushed out.
  always_comb begin
    step        = (rem_q < STEP_MAX) ? rem_q : STEP_MAX;
    lidx        = 6'd32 - {1'b0, step};
    ridx        = step - 5'd1;
    shifted     = work_q;
    shifted_out = carry_q;
    case (kind_q)
      K_LSL: begin
        shifted     = work_q << step;
        shifted_out = work_q[lidx[4:0]];
      end
      K_LSR: begin
        shifted     = work_q >> step;
        shifted_out = work_q[ridx];
      end
      K_ASR: begin
        shifted     = 32'($signed(work_q) >>> step);
        shifted_out = work_q[ridx];
      end
      default: begin
        shifted     = (work_q >> step) | (work_q << lidx);
        shifted_out = shifted[31];
      end
    endcase
  end

  assign accept = start && (state_q != SHIFT);

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    work_d  = work_q;
    carry_d = carry_q;
    rem_d   = rem_q;
    if (flush) begin
      state_d = IDLE;
      work_d  = 32'd0;
      carry_d = 1'b0;
      rem_d   = 5'd0;
    end else if (accept) begin
      // Carry for a zero-length shift is the incoming C flag.
      work_d  = acc_work;
      kind_d  = acc_kind;
      rem_d   = acc_n;
      carry_d = carryIn;
      state_d = (acc_n == 5'd0) ? DONE : SHIFT;
    end else begin
      case (state_q)
        SHIFT: begin
          work_d  = shifted;
          carry_d = shifted_out;
          rem_d   = rem_q - step;
          if (rem_q == step) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      kind_q  <= K_LSL;
      work_q  <= 32'd0;
      carry_q <= 1'b0;
      rem_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      rem_q   <= rem_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign Val2        = work_q;
  assign shift_carry = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Checks three shift_sequencer instances (1, 2 and 4 bits per cycle) driven in
// lockstep against a whole-word arithmetic model of the operand2 rules.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        memInst = 1'b0;
  logic        imm = 1'b0;
  logic        carryIn = 1'b0;
  logic [31:0] Val_Rm = '0;
  logic [11:0] Shift_operand = '0;

  logic        busy_w [3];
  logic        done_w [3];
  logic [31:0] val2_w [3];
  logic        carry_w [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      shift_sequencer #(.BITS_PER_CYCLE(1 << gi)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .flush        (flush),
        .memInst      (memInst),
        .imm          (imm),
        .carryIn      (carryIn),
        .Val_Rm       (Val_Rm),
        .Shift_operand(Shift_operand),
        .busy         (busy_w[gi]),
        .done         (done_w[gi]),
        .Val2         (val2_w[gi]),
        .shift_carry  (carry_w[gi])
      );
    end
  endgenerate

  // Reference: shift the whole word in one go using 64-bit arithmetic.
  function automatic void model(input bit mi, input bit im, input bit ci,
                                input logic [31:0] rm, input logic [11:0] op,
                                output logic [31:0] v, output bit c, output int n);
    logic [31:0] w;
    logic [63:0] t;
    int kind;
    if (mi) begin
      w = {{20{op[11]}}, op}; n = 0; kind = 0;
    end else if (im) begin
      w = {24'd0, op[7:0]}; n = 2 * op[11:8]; kind = 3;
    end else begin
      w = rm; n = int'(op[11:7]); kind = int'(op[6:5]);
    end
    v = w;
    c = ci;
    if (n != 0) begin
      case (kind)
        0: begin t = {32'd0, w} << n; v = t[31:0]; c = t[32]; end
        1: begin t = {w, 32'd0} >> n; v = t[63:32]; c = t[31]; end
        2: begin t = $signed({w, 32'd0}) >>> n; v = t[63:32]; c = t[31]; end
        default: begin t = {w, w} >> n; v = t[31:0]; c = v[31]; end
      endcase
    end
  endfunction

  // Issue one op at the next edge E and watch all instances for up to 40 edges.
  // poke >= 0 re-pulses start (with different operands) in that cycle after E.
  task automatic run_op(input string name, input bit mi, input bit im, input bit ci,
                        input logic [31:0] rm, input logic [11:0] op, input int poke);
    logic [31:0] ev;
    bit ec;
    int n;
    int first [3];
    int cnt [3];
    int busyc [3];
    int lat;
    model(mi, im, ci, rm, op, ev, ec, n);
    for (int i = 0; i < 3; i++) begin first[i] = -1; cnt[i] = 0; busyc[i] = 0; end
    memInst = mi; imm = im; carryIn = ci; Val_Rm = rm; Shift_operand = op; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (done_w[i] === 1'b1) begin
          cnt[i]++;
          if (first[i] < 0) first[i] = c;
        end
        if (busy_w[i] === 1'b1) busyc[i]++;
      end
      if (c == poke) begin
        start = 1'b1; memInst = 1'b0; imm = 1'b0; Val_Rm = ~rm; Shift_operand = 12'h000;
      end
      if (c < 40) begin @(posedge clk); #1; start = 1'b0; end
    end
    for (int i = 0; i < 3; i++) begin
      lat = (n + (1 << i) - 1) / (1 << i);
      checks++;
      if (first[i] !== lat || cnt[i] !== 1) begin
        failures++;
        $display("FAIL %s B=%0d done_timing: got first=%0d count=%0d, want first=%0d count=1",
                 name, 1 << i, first[i], cnt[i], lat);
      end
      checks++;
      if (busyc[i] !== lat + 1) begin
        failures++;
        $display("FAIL %s B=%0d busy_cycles: got %0d, want %0d", name, 1 << i, busyc[i], lat + 1);
      end
      checks++;
      if (val2_w[i] !== ev || carry_w[i] !== ec) begin
        failures++;
        $display("FAIL %s B=%0d result: got Val2=%h C=%b, want Val2=%h C=%b",
                 name, 1 << i, val2_w[i], carry_w[i], ev, ec);
      end
    end
    $display("op %-10s mi=%b im=%b ci=%b rm=%h op=%h n=%0d -> Val2=%h C=%b",
             name, mi, im, ci, rm, op, n, ev, ec);
  endtask

  task automatic check_idle(input string name);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy_w[i] !== 1'b0 || done_w[i] !== 1'b0 || val2_w[i] !== 32'd0 || carry_w[i] !== 1'b0) begin
        failures++;
        $display("FAIL %s B=%0d: got busy=%b done=%b Val2=%h C=%b, want 0 0 00000000 0",
                 name, 1 << i, busy_w[i], done_w[i], val2_w[i], carry_w[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    rst = 1'b0;
    @(posedge clk); #1 check_idle("post_reset");
    $display("reset: outputs cleared");
  endtask

  task automatic test_directed();
    run_op("imm_ror2", 1'b0, 1'b1, 1'b0, 32'h0, 12'h1FF, -1);
    run_op("lsl4", 1'b0, 1'b0, 1'b1, 32'h80000001, 12'h200, -1);
    run_op("ror31", 1'b0, 1'b0, 1'b1, 32'h00000001, 12'hFE0, -1);
    run_op("lsr1", 1'b0, 1'b0, 1'b0, 32'h00000001, 12'h0A0, -1);
    run_op("lsl0", 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 12'h000, -1);
  endtask

  task automatic test_ignore_start();
    run_op("asr8_poke", 1'b0, 1'b0, 1'b1, 32'h80000000, 12'h440, 0);
  endtask

  task automatic test_back_to_back();
    memInst = 1'b1; imm = 1'b1; carryIn = 1'b1; Val_Rm = 32'h12345678;
    Shift_operand = 12'h800; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (done_w[i] !== 1'b1 || val2_w[i] !== 32'hFFFFF800 || carry_w[i] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_mem B=%0d: got done=%b Val2=%h C=%b, want 1 FFFFF800 1",
                 1 << i, done_w[i], val2_w[i], carry_w[i]);
      end
    end
    $display("op b2b_mem   mi=1 im=1 ci=1 op=800 -> Val2=fffff800 C=1");
    run_op("b2b_ror5", 1'b0, 1'b0, 1'b0, 32'h0000_00F3, 12'h2E0, -1);
  endtask

  task automatic test_abort(input bit use_rst);
    string nm;
    nm = use_rst ? "abort_rst" : "abort_flush";
    memInst = 1'b0; imm = 1'b0; carryIn = 1'b1; Val_Rm = $urandom | 32'h1;
    Shift_operand = 12'hFE0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy_w[i] !== 1'b1 || done_w[i] !== 1'b0) begin
        failures++;
        $display("FAIL %s B=%0d pre: got busy=%b done=%b, want 1 0", nm, 1 << i, busy_w[i], done_w[i]);
      end
    end
    if (use_rst) rst = 1'b1;
    else begin flush = 1'b1; start = 1'b1; end
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; start = 1'b0;
    check_idle(nm);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (done_w[i] !== 1'b0 || busy_w[i] !== 1'b0) begin
          checks++; failures++;
          $display("FAIL %s B=%0d late: got done=%b busy=%b at cycle %0d, want 0 0",
                   nm, 1 << i, done_w[i], busy_w[i], c);
        end
      end
    end
    checks++;
    $display("%s: operation abandoned", nm);
    // flush must also win over a start that would otherwise be accepted from IDLE
    if (!use_rst) begin
      memInst = 1'b1; Shift_operand = 12'h7FF; carryIn = 1'b1; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1 start = 1'b0; flush = 1'b0;
      check_idle("flush_over_start");
    end
  endtask

  task automatic test_random();
    logic [11:0] op;
    int form;
    for (int t = 0; t < 30; t++) begin
      form = $urandom_range(0, 3);
      op = 12'($urandom);
      run_op("random", form == 0, (form == 0) ? 1'($urandom) : (form == 1),
             1'($urandom), $urandom, op, -1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_abort(1'b1);
    test_abort(1'b0);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
